rx_sync_track: RTL and testbench
================================

RX_SYNC_TRACK -- requirements
Module: rx_sync_track

Interface
REQ-001 Parameter HZ_CNT, 99, local hz period minus one; hz period = HZ_CNT+1 cycles.
REQ-002 Parameter SYN_DIV, 3, hz periods per transmitted sync; NOM = SYN_DIV*(HZ_CNT+1) = 300 cycles.
REQ-003 Parameter TOL, 4, accepted sync jitter, +/- cycles.
REQ-004 Parameter LOCK_N, 3, consecutive in-window intervals required for lock.
REQ-005 Parameter MISS_MAX, 2, missed sync periods tolerated in holdover.
REQ-006 clk_10M  in  1  10 MHz clock, all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high; clock clk_10M.
REQ-008 syn_in  in  1  raw sync pulse from transmitter, asynchronous, active-high, >=1 cycle wide.
REQ-009 hz  out  1  one-cycle recovered tick pulse, only while locked.
REQ-010 time_second  out  8  recovered tick count, wraps 255->0.
REQ-011 locked  out  1  high in LOCK or HOLD.
REQ-012 sync_err  out  1  one-cycle pulse on out-of-window edge in LOCK/HOLD.
REQ-013 period  out  16  last measured edge-to-edge interval in cycles.
REQ-014 state  out  2  FSM state: SEARCH=0, ACQ=1, LOCK=2, HOLD=3.
REQ-015 err_cnt  out  8  sync_err count; port exists only with SYNC_ERR_CNT_EN.

Function
REQ-016 syn_in shall pass a 2-FF synchronizer plus edge register; evt = sync2 & ~sync3; FSM acts at the 3rd rising edge after syn_in rises.
REQ-017 pcnt (16b) shall load 1 on evt, else increment, saturating at 0xFFFF; on evt period <= pcnt.
REQ-018 ACQ window: NOM-TOL <= pcnt <= NOM+TOL (296..304).
REQ-019 lph (local phase, 0..NOM-1) and hcnt (0..HZ_CNT) free-run and wrap; accept cycle is phase 0 (next cycle lph=1, hcnt=1).
REQ-020 LOCK/HOLD window: lph <= TOL (late) or lph >= NOM-TOL (early).
REQ-021 hz shall pulse when locked and (hcnt==HZ_CNT or early accept); never two pulses in one cycle; time_second += 1 per hz.
REQ-022 SEARCH: evt -> ACQ, good=0.
REQ-023 ACQ: in-window evt -> good+1; good reaching LOCK_N -> LOCK with realign; out-of-window evt -> good=0; pcnt > NOM+TOL without evt -> SEARCH.
REQ-024 LOCK: in-window evt -> realign, miss=0; out-of-window evt -> sync_err, ACQ, good=0; pcnt == NOM+TOL+1 -> HOLD, miss=1.
REQ-025 HOLD: hz continues; each lph wrap increments miss; wrap with miss==MISS_MAX -> SEARCH; in-window evt -> LOCK, realign, miss=0; out-of-window evt -> sync_err, ACQ.
REQ-026 time_second shall clear on entry to SEARCH and hold its value in ACQ.
REQ-027 evt coincident with a timeout: evt wins.
REQ-028 All outputs registered; locked/state update in the cycle of the transition.

Reset
REQ-029 rst shall force SEARCH; hz, locked, sync_err = 0; time_second, period, pcnt, lph, hcnt, good, miss, err_cnt = 0; synchronizer flops = 0.
REQ-030 rst mid-operation shall take effect at the next clock edge, discarding any in-flight evt.

Configuration
REQ-031 Macro SYNC_ERR_CNT_EN defined: err_cnt increments on each sync_err, saturating at 255, cleared only by rst.
REQ-032 SYNC_ERR_CNT_EN undefined: err_cnt port and counter absent; all other behaviour identical.

Verification
REQ-033 Reset, then 4 syn_in pulses 300 cycles apart -> state 0->1->2; locked=1 three edges after 4th pulse rises; hz every 100 cycles; time_second 1,2,3.
REQ-034 Locked, edges at intervals 296 and 304 -> locked stays 1, sync_err 0; the 296 edge emits hz that cycle; no hz lost or duplicated.
REQ-035 Locked, edge 250 cycles after last -> sync_err one cycle, state=1, locked=0, time_second held.
REQ-036 Locked, syn_in stopped -> state=3 at pcnt=305, hz continues; SEARCH after MISS_MAX further wraps, locked=0, time_second=0.
REQ-037 rst asserted mid-LOCK for 1 cycle -> all outputs 0 next cycle; relock requires 4 fresh edges.
REQ-038 SYNC_ERR_CNT_EN defined, 260 out-of-window edges -> err_cnt saturates at 255.

Source files
------------

// File: rtl/rx_sync_track.sv
`timescale 1ns/1ps
// rx_sync_track: recovers a local hz tick and second count from a periodic, jittery sync pulse.
// Define SYNC_ERR_CNT_EN to add the saturating sync-error counter and its err_cnt port.
module rx_sync_track #(
  parameter int unsigned HZ_CNT   = 99,
  parameter int unsigned SYN_DIV  = 3,
  parameter int unsigned TOL      = 4,
  parameter int unsigned LOCK_N   = 3,
  parameter int unsigned MISS_MAX = 2
) (
  input  logic        clk_10M,
  input  logic        rst,
  input  logic        syn_in,
  output logic        hz,
  output logic [7:0]  time_second,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] period,
  output logic [1:0]  state
`ifdef SYNC_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam int unsigned NOM = SYN_DIV * (HZ_CNT + 1);
  localparam int unsigned LW  = $clog2(NOM);
  localparam int unsigned HW  = $clog2(HZ_CNT + 1);
  localparam int unsigned GW  = $clog2(LOCK_N + 1);
  localparam int unsigned MW  = $clog2(MISS_MAX + 1);
  localparam logic [15:0] PCNT_LO = 16'(NOM - TOL);
  localparam logic [15:0] PCNT_HI = 16'(NOM + TOL);
  localparam logic [15:0] PCNT_TO = 16'(NOM + TOL + 1);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQ = 2'd1, LOCK = 2'd2, HOLD = 2'd3} st_t;

  st_t           st_q, st_d;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          sync1, sync2, sync3;
  logic [15:0]   pcnt;
  logic [LW-1:0] lph;
  logic [HW-1:0] hcnt;
  logic          evt, acq_win, lock_win, lph_wrap, hcnt_wrap;
  logic          realign, early, err_d, hz_d, locked_d;

  assign evt       = sync2 & ~sync3;
  assign acq_win   = (pcnt >= PCNT_LO) && (pcnt <= PCNT_HI);
  assign lock_win  = (lph <= LW'(TOL)) || (lph >= LW'(NOM - TOL));
  assign lph_wrap  = (lph == LW'(NOM - 1));
  assign hcnt_wrap = (hcnt == HW'(HZ_CNT));
  assign state     = st_q;

  // Next-state and per-cycle decisions; an edge always takes priority over a timeout.
  always_comb begin
    st_d    = st_q;
    good_d  = good_q;
    miss_d  = miss_q;
    realign = 1'b0;
    early   = 1'b0;
    err_d   = 1'b0;
    case (st_q)
      SEARCH: begin
        if (evt) begin
          st_d   = ACQ;
          good_d = '0;
        end
      end
      ACQ: begin
        if (evt) begin
          if (acq_win) begin
            good_d = good_q + GW'(1);
            if (good_d == GW'(LOCK_N)) begin
              st_d    = LOCK;
              realign = 1'b1;
              miss_d  = '0;
            end
          end else begin
            good_d = '0;
          end
        end else if (pcnt > PCNT_HI) begin
          st_d = SEARCH;
        end
      end
      LOCK, HOLD: begin
        if (evt) begin
          if (lock_win) begin
            st_d    = LOCK;
            realign = 1'b1;
            miss_d  = '0;
            early   = (lph >= LW'(NOM - TOL));
          end else begin
            st_d   = ACQ;
            good_d = '0;
            err_d  = 1'b1;
          end
        end else if (st_q == LOCK) begin
          if (pcnt == PCNT_TO) begin
            st_d   = HOLD;
            miss_d = MW'(1);
          end
        end else if (lph_wrap) begin
          if (miss_q == MW'(MISS_MAX)) st_d = SEARCH;
          else                         miss_d = miss_q + MW'(1);
        end
      end
      default: st_d = SEARCH;
    endcase
    locked_d = (st_d == LOCK) || (st_d == HOLD);
    hz_d     = locked_d && (hcnt_wrap || early);
  end

  always_ff @(posedge clk_10M) begin
    if (rst) begin
      st_q   <= SEARCH;
      good_q <= '0;
      miss_q <= '0;
    end else begin
      st_q   <= st_d;
      good_q <= good_d;
      miss_q <= miss_d;
    end
  end

  // Synchronizer, interval measurement, local phase and registered outputs.
  always_ff @(posedge clk_10M) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      pcnt        <= '0;
      period      <= '0;
      lph         <= '0;
      hcnt        <= '0;
      hz          <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      time_second <= '0;
    end else begin
      sync1 <= syn_in;
      sync2 <= sync1;
      sync3 <= sync2;
      if (evt) begin
        pcnt   <= 16'd1;
        period <= pcnt;
      end else if (pcnt != 16'hFFFF) begin
        pcnt <= pcnt + 16'd1;
      end
      if (realign) begin
        lph  <= LW'(1);
        hcnt <= HW'(1);
      end else begin
        lph  <= lph_wrap  ? '0 : lph + LW'(1);
        hcnt <= hcnt_wrap ? '0 : hcnt + HW'(1);
      end
      hz       <= hz_d;
      locked   <= locked_d;
      sync_err <= err_d;
      if (st_d == SEARCH) time_second <= '0;
      else if (hz_d)      time_second <= time_second + 8'd1;
    end
  end

`ifdef SYNC_ERR_CNT_EN
  always_ff @(posedge clk_10M) begin
    if (rst)                           err_cnt <= '0;
    else if (err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_rx_sync_track.sv
`timescale 1ns/1ps
// Directed bench for rx_sync_track: vector table of sync intervals plus hand-built holdover,
// acquisition-timeout, reset and (with SYNC_ERR_CNT_EN) error-counter sequences.
module tb_rx_sync_track;

  logic        clk_10M = 1'b0;
  logic        rst = 1'b1;
  logic        syn_in = 1'b0;
  logic        hz, locked, sync_err;
  logic [7:0]  time_second;
  logic [15:0] period;
  logic [1:0]  state;
  int          checks = 0;
  int          failures = 0;
`ifdef SYNC_ERR_CNT_EN
  logic [7:0]  err_cnt;
  logic        syn_s = 1'b0;
  logic        hz_s, locked_s, sync_err_s;
  logic [7:0]  ts_s, err_cnt_s;
  logic [15:0] period_s;
  logic [1:0]  state_s;
`endif

  always #50 clk_10M = ~clk_10M;

  rx_sync_track dut (
    .clk_10M(clk_10M), .rst(rst), .syn_in(syn_in), .hz(hz), .time_second(time_second),
    .locked(locked), .sync_err(sync_err), .period(period), .state(state)
`ifdef SYNC_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

`ifdef SYNC_ERR_CNT_EN
  // Shortened timing (NOM=10, TOL=1, one interval to lock) so hundreds of errors stay cheap.
  rx_sync_track #(.HZ_CNT(9), .SYN_DIV(1), .TOL(1), .LOCK_N(1), .MISS_MAX(2)) u_small (
    .clk_10M(clk_10M), .rst(rst), .syn_in(syn_s), .hz(hz_s), .time_second(ts_s),
    .locked(locked_s), .sync_err(sync_err_s), .period(period_s), .state(state_s),
    .err_cnt(err_cnt_s)
  );
`endif

  typedef struct {
    int gap; int st; int lk; int er; int per; int ts; int hzv;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk_10M);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Entered 3 cycles after the previous pulse rose; returns at the edge where its evt is acted on.
  task automatic pulse_and_settle(input int gap);
    repeat (gap - 3) tick();
    syn_in = 1'b1;
    tick();
    syn_in = 1'b0;
    tick();
    tick();
  endtask

`ifdef SYNC_ERR_CNT_EN
  task automatic small_pulse(input int gap);
    syn_s = 1'b1;
    tick();
    syn_s = 1'b0;
    repeat (gap - 1) tick();
  endtask
`endif

  task automatic check_all(input string tag, input int st, input int lk, input int er,
                           input int per, input int ts, input int hzv);
    check({tag, "_state"},  int'(state), st);
    check({tag, "_locked"}, int'(locked), lk);
    check({tag, "_syncerr"}, int'(sync_err), er);
    check({tag, "_period"}, int'(period), per);
    check({tag, "_tsec"},   int'(time_second), ts);
    check({tag, "_hz"},     int'(hz), hzv);
  endtask

  initial begin
    //          gap  st lk er per  ts hz
    vecs[0]  = '{3,   1, 0, 0, 2,   0, 0};
    vecs[1]  = '{300, 1, 0, 0, 300, 0, 0};
    vecs[2]  = '{300, 1, 0, 0, 300, 0, 0};
    vecs[3]  = '{300, 2, 1, 0, 300, 0, 0};
    vecs[4]  = '{296, 2, 1, 0, 296, 3, 1};
    vecs[5]  = '{304, 2, 1, 0, 304, 6, 0};
    vecs[6]  = '{300, 2, 1, 0, 300, 9, 0};
    vecs[7]  = '{250, 1, 0, 1, 250, 11, 0};
    vecs[8]  = '{200, 1, 0, 0, 200, 11, 0};
    vecs[9]  = '{300, 1, 0, 0, 300, 11, 0};
    vecs[10] = '{300, 1, 0, 0, 300, 11, 0};
    vecs[11] = '{300, 2, 1, 0, 300, 11, 0};
    vecs[12] = '{300, 2, 1, 0, 300, 14, 0};

    repeat (3) tick();
    check_all("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      pulse_and_settle(vecs[i].gap);
      check_all($sformatf("v%0d", i), vecs[i].st, vecs[i].lk, vecs[i].er,
                vecs[i].per, vecs[i].ts, vecs[i].hzv);
`ifdef SYNC_ERR_CNT_EN
      if (i == 7) check("v7_errcnt", int'(err_cnt), 1);
`endif
    end

    // Holdover: sync stops right after a realign.
    repeat (304) tick();
    check("hold_pre_state", int'(state), 2);
    tick();
    check("hold_state", int'(state), 3);
    check("hold_locked", int'(locked), 1);
    check("hold_tsec", int'(time_second), 17);
    repeat (593) tick();
    check("hold_end_state", int'(state), 3);
    check("hold_end_tsec", int'(time_second), 22);
    tick();
    check_all("lost", 0, 0, 0, 300, 0, 0);

    // Acquisition: edge coinciding with timeout is taken, then a real timeout.
    pulse_and_settle(3);
    check("acq_state", int'(state), 1);
    pulse_and_settle(305);
    check("acq305_state", int'(state), 1);
    check("acq305_period", int'(period), 305);
    check("acq305_syncerr", int'(sync_err), 0);
    repeat (304) tick();
    check("acq_to_pre", int'(state), 1);
    tick();
    check("acq_to_state", int'(state), 0);

    // Reset mid-lock, then an in-flight edge discarded by reset, then relock.
    pulse_and_settle(3);
    repeat (3) pulse_and_settle(300);
    check("relock_locked", int'(locked), 1);
    repeat (150) tick();
    check("relock_tsec", int'(time_second), 1);
    rst = 1'b1;
    tick();
    check_all("midrst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    syn_in = 1'b1;
    tick();
    syn_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("inflight_state", int'(state), 0);
    pulse_and_settle(3);
    pulse_and_settle(300);
    pulse_and_settle(300);
    check("fresh3_state", int'(state), 1);
    pulse_and_settle(300);
    check("fresh4_state", int'(state), 2);
    check("fresh4_locked", int'(locked), 1);

`ifdef SYNC_ERR_CNT_EN
    small_pulse(10);
    for (int i = 0; i < 260; i++) begin
      small_pulse(5);
      small_pulse(10);
      if (i == 0)   check("errcnt_1", int'(err_cnt_s), 1);
      if (i == 254) check("errcnt_255", int'(err_cnt_s), 255);
    end
    check("errcnt_sat", int'(err_cnt_s), 255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
